color_cmd_gen: RTL

Command generator directly upstream of the two-state Color FSM (Blue/Red). Synchronises and debounces a raw push-button and, optionally, a free-running auto-toggle timer. Arbitrates both sources under a minimum-spacing lockout. Drives the FSM's 2-bit `in` command: a one-cycle toggle pulse per accepted event, otherwise a hold code.

---
 rtl/color_cmd_pkg.sv | 15 +
 rtl/color_cmd_gen_debounce.sv | 83 ++++++++
 rtl/color_cmd_gen.sv | 91 +++++++++
 3 files changed

// File: rtl/color_cmd_pkg.sv
// rtl/color_cmd_pkg.sv - shared command codes and debounce state type for color_cmd_gen
package color_cmd_pkg;

    // Command codes driven onto the Color FSM "in" port
    localparam logic [1:0] CMD_HOLD   = 2'h0;
    localparam logic [1:0] CMD_TOGGLE = 2'h1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } debounce_state_t;

endpackage

// File: rtl/color_cmd_gen_debounce.sv
// rtl/color_cmd_gen_debounce.sv - button synchroniser and debounce FSM
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   btn        : raw asynchronous button level
//   press_evt  : one-cycle pulse per accepted press (combinational from state)
//   pressed    : registered debounced button level
module btn_debounce
    import color_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_evt,
    output logic pressed
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    logic            sync_1;
    logic            btn_s;
    logic [DW-1:0]   dcnt;
    debounce_state_t state;

    // The press is accepted in the cycle the counter reaches its last value
    // while the synchronised level is still high.
    assign press_evt = (state == ARM) && btn_s && (dcnt == DLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1  <= 1'b0;
            btn_s   <= 1'b0;
            dcnt    <= '0;
            state   <= IDLE;
            pressed <= 1'b0;
        end else begin
            sync_1 <= btn;
            btn_s  <= sync_1;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= ARM;
                        dcnt  <= DW'(1);
                    end
                end
                ARM: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (dcnt == DLAST) begin
                        state   <= PRESSED;
                        pressed <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE;
                        dcnt  <= DW'(1);
                    end
                end
                RELEASE: begin
                    // A short bounce back high returns to PRESSED without an event
                    if (btn_s) begin
                        state <= PRESSED;
                    end else if (dcnt == DLAST) begin
                        state   <= IDLE;
                        pressed <= 1'b0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/color_cmd_gen.sv
// rtl/color_cmd_gen.sv - command generator feeding the Color FSM toggle/hold input
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   btn         : raw asynchronous push-button level
//   auto_en     : enable for the free-running auto-toggle timer
//   cmd         : registered command, CMD_TOGGLE for one cycle per issued event
//   pressed     : registered debounced button level
//   toggle_cnt  : count of issued toggles, wraps
module color_cmd_gen
    import color_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PERIOD          = 16,
    parameter int MIN_GAP         = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic             auto_en,
    output logic [1:0]       cmd,
    output logic             pressed,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int AW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [AW-1:0] ALAST = AW'(PERIOD - 1);
    localparam logic [GW-1:0] GLOAD = GW'(MIN_GAP);

    logic          press_evt;
    logic          auto_en_q;
    logic [AW-1:0] acnt;
    logic          auto_evt;
    logic [GW-1:0] gap;
    logic          pending;
    logic          req;
    logic          issue;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .press_evt(press_evt),
        .pressed  (pressed)
    );

    // The enable is registered so the timer starts counting from a clean
    // zero one cycle after enable is sampled; the first auto event then
    // lands exactly PERIOD edges after the enabling edge.
    assign auto_evt = auto_en_q && (acnt == ALAST);
    assign req      = press_evt | auto_evt;
    assign issue    = (gap == '0) && (req || pending);

    always_ff @(posedge clk) begin
        if (rst) begin
            auto_en_q  <= 1'b0;
            acnt       <= '0;
            gap        <= '0;
            pending    <= 1'b0;
            cmd        <= CMD_HOLD;
            toggle_cnt <= '0;
        end else begin
            auto_en_q <= auto_en;
            if (!auto_en_q || (acnt == ALAST)) begin
                acnt <= '0;
            end else begin
                acnt <= acnt + 1'b1;
            end

            if (issue) begin
                cmd        <= CMD_TOGGLE;
                gap        <= GLOAD;
                pending    <= 1'b0;
                toggle_cnt <= toggle_cnt + 1'b1;
            end else begin
                cmd <= CMD_HOLD;
                if (gap != '0) begin
                    gap <= gap - 1'b1;
                end
                // Requests during lockout collapse into a single deferred toggle
                if (req) begin
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule
